imm_extend_pipe: RTL and testbench



---
 rtl/imm_extend_pipe.sv | 126 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a 2-entry skid buffer on a valid/ready handshake.
// Optional saturating illegal-mode counter enabled by defining IMMEXT_ILLEGAL_CNT_EN.
module imm_extend_pipe #(
  parameter int INSTR_W   = 11,
  parameter int EXT_W     = 18,
  parameter int DP_IMM_W  = 4,
  parameter int MEM_IMM_W = 4,
  parameter int BR_SHIFT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [2:0]         ImmSrc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXT_W-1:0]   ExtImm,
  output logic               illegal
`ifdef IMMEXT_ILLEGAL_CNT_EN
  ,
  output logic [7:0]         illegal_cnt
`endif
);

  // Handshake: a beat moves when valid && ready at a clk edge; valid never waits on ready,
  // and in_ready is a flop that tracks "skid entry empty" so it never depends on out_ready.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [EXT_W-1:0] r_skid_data;
  logic             r_skid_ill;

  logic [EXT_W-1:0] w_ext;
  logic             w_ill;
  logic [EXT_W-1:0] w_sx_instr;
  logic             w_acc;
  logic             w_out;

  assign w_acc      = in_valid & in_ready;
  assign w_out      = out_valid & out_ready;
  assign w_sx_instr = {{(EXT_W-INSTR_W){Instr[INSTR_W-1]}}, Instr};

  always_comb begin
    w_ext = '0;
    w_ill = 1'b0;
    case (ImmSrc)
      3'b000: w_ext = {{(EXT_W-DP_IMM_W){1'b0}}, Instr[DP_IMM_W-1:0]};
      3'b001: w_ext = {{(EXT_W-MEM_IMM_W){1'b0}}, Instr[MEM_IMM_W-1:0]};
      3'b010: w_ext = w_sx_instr << BR_SHIFT;
      3'b011: w_ext = {{(EXT_W-DP_IMM_W){Instr[DP_IMM_W-1]}}, Instr[DP_IMM_W-1:0]};
      3'b100: w_ext = {Instr, {(EXT_W-INSTR_W){1'b0}}};
      default: begin
        w_ext = '0;
        w_ill = 1'b1;
      end
    endcase
  end

  // The main entry is the output register itself; the skid entry only fills when
  // a new beat arrives while main is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      ExtImm      <= '0;
      illegal     <= 1'b0;
      r_skid_data <= '0;
      r_skid_ill  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            ExtImm    <= w_ext;
            illegal   <= w_ill;
            out_valid <= 1'b1;
            r_state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_out) begin
            ExtImm  <= w_ext;
            illegal <= w_ill;
          end else if (w_acc) begin
            r_skid_data <= w_ext;
            r_skid_ill  <= w_ill;
            in_ready    <= 1'b0;
            r_state     <= ST_FULL;
          end else if (w_out) begin
            out_valid <= 1'b0;
            r_state   <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out) begin
            ExtImm   <= r_skid_data;
            illegal  <= r_skid_ill;
            in_ready <= 1'b1;
            r_state  <= ST_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef IMMEXT_ILLEGAL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= 8'd0;
    end else if (w_acc && w_ill && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: hand-computed vectors, expected queue, backpressure and reset.
module tb_imm_extend_pipe;

  localparam int INSTR_W = 11;
  localparam int EXT_W   = 18;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] Instr;
  logic [2:0]         ImmSrc;
  logic               out_valid;
  logic               out_ready;
  logic [EXT_W-1:0]   ExtImm;
  logic               illegal;
`ifdef IMMEXT_ILLEGAL_CNT_EN
  logic [7:0]         illegal_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int last_wait;

  logic [EXT_W:0] exp_q[$];

  imm_extend_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Instr     (Instr),
    .ImmSrc    (ImmSrc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ExtImm    (ExtImm),
    .illegal   (illegal)
`ifdef IMMEXT_ILLEGAL_CNT_EN
    ,
    .illegal_cnt (illegal_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drives one beat from a negedge and returns just after the accepting posedge.
  task automatic send(input logic [2:0] src, input logic [INSTR_W-1:0] ins,
                      input logic [EXT_W-1:0] exp_d, input logic exp_i);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1;
    ImmSrc   = src;
    Instr    = ins;
    exp_q.push_back({exp_i, exp_d});
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    last_wait = cnt;
    check("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // scoreboard: pops one expected entry per output transfer
  initial begin
    logic [EXT_W:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ext_imm", {14'd0, ExtImm}, {14'd0, e[EXT_W-1:0]});
          check("illegal", {31'd0, illegal}, {31'd0, e[EXT_W]});
        end
      end
    end
  end

  initial begin
    int cnt;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Instr     = '0;
    ImmSrc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ext", {14'd0, ExtImm}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef IMMEXT_ILLEGAL_CNT_EN
    check("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
`endif
    out_ready = 1'b1;

    // zero-extend modes and latency 1
    send(3'b000, 11'h7A5, 18'h00005, 1'b0);
    idle();
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    send(3'b001, 11'h7A5, 18'h00005, 1'b0);
    idle();

    // branch offsets back-to-back
    send(3'b010, 11'h400, 18'h3F000, 1'b0);
    send(3'b010, 11'h3FF, 18'h00FFC, 1'b0);
    check("b2b_no_wait", last_wait, 32'd0);
    idle();
    check("b2b_valid", {31'd0, out_valid}, 32'd1);

    send(3'b011, 11'h00C, 18'h3FFFC, 1'b0);
    send(3'b100, 11'h001, 18'h00080, 1'b0);
    send(3'b101, 11'h7FF, 18'h00000, 1'b1);
    send(3'b111, 11'h123, 18'h00000, 1'b1);
    send(3'b000, 11'h00A, 18'h0000A, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    check("drain1", exp_q.size(), 32'd0);

    // backpressure: A and B fill the buffer, C must wait
    out_ready = 1'b0;
    send(3'b000, 11'h003, 18'h00003, 1'b0);
    send(3'b000, 11'h005, 18'h00005, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_stable", {14'd0, ExtImm}, 32'h3);
    end
    out_ready = 1'b1;
    send(3'b000, 11'h007, 18'h00007, 1'b0);
    idle();
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("drain2", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // reset while FULL discards everything
    out_ready = 1'b0;
    send(3'b000, 11'h001, 18'h00001, 1'b0);
    send(3'b000, 11'h002, 18'h00002, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_ext", {14'd0, ExtImm}, 32'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst2_idle", {31'd0, out_valid}, 32'd0);

`ifdef IMMEXT_ILLEGAL_CNT_EN
    for (int i = 0; i < 300; i++) send(3'b101, 11'h7FF, 18'h00000, 1'b1);
    idle();
    @(negedge clk);
    check("illegal_cnt_sat", {24'd0, illegal_cnt}, 32'd255);
`else
    send(3'b110, 11'h7FF, 18'h00000, 1'b1);
    idle();
`endif
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("drain3", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
